// File: rtl/demux_sel_sequencer.sv
// Feeds a 1x8 demux: latches a data word and channel mask, then walks the enabled
// channels in ascending order, presenting data[ch] with sel=ch for HOLD cycles each.
module demux_sel_sequencer #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic [7:0] mask_in,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       in,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [3:0] HoldLast = 4'(HOLD - 1);

  state_e     r_state;
  logic [7:0] r_data;
  logic [7:0] r_mask;
  logic [3:0] r_hold;
  logic [2:0] r_sel;
  logic       r_in;
  logic       r_out_valid;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_frame_cnt;

  logic [2:0] w_first_sel;
  logic [2:0] w_next_sel;
  logic       w_has_next;

  // Lowest set bit of the incoming mask; descending loop lets lower bits win.
  always_comb begin
    w_first_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_in[i]) w_first_sel = 3'(i);
    end
  end

  // Lowest set mask bit strictly above the current channel; none exists past channel 7.
  always_comb begin
    w_next_sel = 3'd0;
    w_has_next = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i] && (3'(i) > r_sel)) begin
        w_next_sel = 3'(i);
        w_has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_data      <= 8'd0;
      r_mask      <= 8'd0;
      r_hold      <= 4'd0;
      r_sel       <= 3'd0;
      r_in        <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (load_valid) begin
            r_data <= data_in;
            r_mask <= mask_in;
            r_hold <= 4'd0;
            r_busy <= 1'b1;
            if (mask_in != 8'd0) begin
              r_state     <= StScan;
              r_sel       <= w_first_sel;
              r_in        <= data_in[w_first_sel];
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= StDone;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        StScan: begin
          if (r_hold == HoldLast) begin
            r_hold <= 4'd0;
            if (w_has_next) begin
              r_sel <= w_next_sel;
              r_in  <= r_data[w_next_sel];
            end else begin
              r_state     <= StDone;
              r_sel       <= 3'd0;
              r_in        <= 1'b0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign load_ready = (r_state == StIdle);
  assign in         = r_in;
  assign sel        = r_sel;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: HOLD=1 and HOLD=3 instances, per-cycle scoreboard of
// expected outputs built from a simple channel-walk model, plus hand-written corner sequences.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] mask_in = 8'd0;
  logic       lv1 = 1'b0;
  logic       lv3 = 1'b0;

  logic       lr1, in1, ov1, busy1, done1;
  logic [2:0] sel1;
  logic [7:0] cnt1;
  logic       lr3, in3, ov3, busy3, done3;
  logic [2:0] sel3;
  logic [7:0] cnt3;

  always #5 clk = ~clk;

  demux_sel_sequencer #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mask_in(mask_in), .load_valid(lv1),
    .load_ready(lr1), .in(in1), .sel(sel1), .out_valid(ov1), .busy(busy1), .done(done1),
    .frame_cnt(cnt1)
  );

  demux_sel_sequencer #(.HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mask_in(mask_in), .load_valid(lv3),
    .load_ready(lr3), .in(in3), .sel(sel3), .out_valid(ov3), .busy(busy3), .done(done3),
    .frame_cnt(cnt3)
  );

  typedef struct packed {
    logic       ov;
    logic [2:0] sel;
    logic       in;
    logic       done;
    logic       busy;
    logic       lr;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    bit         d3;
    logic [7:0] data;
    logic [7:0] mask;
    int         done_cyc;
  } vec_t;

  obs_t       sb_q[$];
  obs_t       obs;
  bit         which = 1'b0;
  logic [7:0] exp_cnt [2];
  int         n_cmp = 0;
  int         n_err = 0;
  vec_t       vecs [6];

  always_comb begin
    obs = which ? {ov3, sel3, in3, done3, busy3, lr3, cnt3}
                : {ov1, sel1, in1, done1, busy1, lr1, cnt1};
  end

  function automatic obs_t idle_rec(input logic [7:0] c);
    return '{ov: 1'b0, sel: 3'd0, in: 1'b0, done: 1'b0, busy: 1'b0, lr: 1'b1, cnt: c};
  endfunction

  task automatic check(input string name, input obs_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got ov=%0b sel=%0d in=%0b done=%0b busy=%0b rdy=%0b cnt=%0d, required ov=%0b sel=%0d in=%0b done=%0b busy=%0b rdy=%0b cnt=%0d",
               name, obs.ov, obs.sel, obs.in, obs.done, obs.busy, obs.lr, obs.cnt,
               exp.ov, exp.sel, exp.in, exp.done, exp.busy, exp.lr, exp.cnt);
    end
  endtask

  // Expected per-cycle trace for one accepted frame: scan cycles, done cycle, idle cycle.
  task automatic push_trace(input bit d3, input logic [7:0] d, input logic [7:0] m,
                            input int hold);
    for (int ch = 0; ch < 8; ch++) begin
      if (m[ch]) begin
        for (int h = 0; h < hold; h++) begin
          sb_q.push_back('{ov: 1'b1, sel: 3'(ch), in: d[ch], done: 1'b0, busy: 1'b1,
                           lr: 1'b0, cnt: exp_cnt[d3]});
        end
      end
    end
    exp_cnt[d3] = exp_cnt[d3] + 8'd1;
    sb_q.push_back('{ov: 1'b0, sel: 3'd0, in: 1'b0, done: 1'b1, busy: 1'b1, lr: 1'b0,
                     cnt: exp_cnt[d3]});
    sb_q.push_back(idle_rec(exp_cnt[d3]));
  endtask

  task automatic drive_lv(input bit d3, input logic v);
    if (d3) lv3 = v;
    else lv1 = v;
  endtask

  // Entered at a negedge in an idle cycle; leaves at the negedge of the following idle cycle.
  task automatic run_frame(input bit d3, input logic [7:0] d, input logic [7:0] m,
                           input int done_cyc, input string name);
    int cyc;
    int seen;
    which = d3;
    #1;
    check({name, "/pre"}, idle_rec(exp_cnt[d3]));
    data_in = d;
    mask_in = m;
    drive_lv(d3, 1'b1);
    @(posedge clk);
    #1;
    drive_lv(d3, 1'b0);
    data_in = 8'($urandom);
    mask_in = 8'($urandom);
    push_trace(d3, d, m, d3 ? 3 : 1);
    cyc  = 0;
    seen = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      check($sformatf("%s/c%0d", name, cyc), sb_q.pop_front());
      if (obs.done === 1'b1 && seen == 0) seen = cyc;
    end
    if (done_cyc > 0) begin
      n_cmp++;
      if (seen != done_cyc) begin
        n_err++;
        $display("FAIL %s/done_cycle: got %0d, required %0d", name, seen, done_cyc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len_a;
    logic [7:0] saved;

    vecs[0] = '{d3: 1'b0, data: 8'hA5, mask: 8'hFF, done_cyc: 9};
    vecs[1] = '{d3: 1'b0, data: 8'h80, mask: 8'h81, done_cyc: 3};
    vecs[2] = '{d3: 1'b0, data: 8'h5A, mask: 8'h00, done_cyc: 1};
    vecs[3] = '{d3: 1'b1, data: 8'h04, mask: 8'h0C, done_cyc: 7};
    vecs[4] = '{d3: 1'b0, data: 8'h3C, mask: 8'h5A, done_cyc: 5};
    vecs[5] = '{d3: 1'b1, data: 8'hFF, mask: 8'h80, done_cyc: 4};
    exp_cnt[0] = 8'd0;
    exp_cnt[1] = 8'd0;

    // Reset held with a handshake offered: reset must win.
    lv1 = 1'b1;
    lv3 = 1'b1;
    mask_in = 8'hFF;
    repeat (3) @(negedge clk);
    lv1 = 1'b0;
    lv3 = 1'b0;
    rst_n = 1'b1;
    which = 1'b0;
    #1;
    check("reset/dut1", idle_rec(8'd0));
    which = 1'b1;
    #1;
    check("reset/dut3", idle_rec(8'd0));
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].d3, vecs[v].data, vecs[v].mask, vecs[v].done_cyc,
                $sformatf("vec%0d", v));
    end

    // Reset during cycle 4 of an A5/FF scan.
    which = 1'b0;
    #1;
    check("rst_mid/pre", idle_rec(exp_cnt[0]));
    data_in = 8'hA5;
    mask_in = 8'hFF;
    lv1 = 1'b1;
    @(posedge clk);
    #1;
    lv1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid/c%0d", c),
            '{ov: 1'b1, sel: 3'(c - 1), in: data_in[c - 1], done: 1'b0, busy: 1'b1,
              lr: 1'b0, cnt: exp_cnt[0]});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt[0] = 8'd0;
    exp_cnt[1] = 8'd0;
    check("rst_mid/after", idle_rec(8'd0));
    which = 1'b1;
    #1;
    check("rst_mid/dut3", idle_rec(8'd0));
    which = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid/quiet%0d", c), idle_rec(8'd0));
    end
    run_frame(1'b0, 8'hA5, 8'hFF, 9, "rst_mid/rerun");

    // load_valid held through a scan with changing data: second frame waits for load_ready.
    which = 1'b0;
    #1;
    check("hold_lv/pre", idle_rec(exp_cnt[0]));
    data_in = 8'h0F;
    mask_in = 8'h03;
    lv1 = 1'b1;
    @(posedge clk);
    #1;
    data_in = 8'hF0;
    mask_in = 8'hF0;
    push_trace(1'b0, 8'h0F, 8'h03, 1);
    len_a = sb_q.size();
    push_trace(1'b0, 8'hF0, 8'hF0, 1);
    for (int i = 0; sb_q.size() > 0; i++) begin
      @(negedge clk);
      check($sformatf("hold_lv/c%0d", i + 1), sb_q.pop_front());
      if (i == len_a) lv1 = 1'b0;
    end

    // 256 empty frames bring the counter back around.
    saved = exp_cnt[0];
    for (int k = 0; k < 256; k++) begin
      run_frame(1'b0, 8'($urandom), 8'h00, (k == 0) ? 1 : 0, "zero");
    end
    n_cmp++;
    if (cnt1 !== saved) begin
      n_err++;
      $display("FAIL wrap256: got cnt=%0d, required %0d", cnt1, saved);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
